fft_seq_ctrl: RTL
=================

# fft_seq_ctrl

Parametrised control sequencer for the FFT accelerator. It supports run-time transform size, forward and inverse modes, and an optional chained FFT → filter → IFFT pass. It sits between the host/memory-controller handshake and the datapath (in-FIFO loader, butterfly/RAM engine, filter multiplier, out-FIFO unloader) and sequences the load, calculate, filter and unload phases. It generates the stage and cycle counters the butterfly engine and twiddle ROM consume.

## Interface
- MAX_LOG2N, 10, largest supported transform is 2^MAX_LOG2N points.
- MIN_LOG2N, 3, smallest supported transform.
- SIG_W, 18, width of the signal number.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- startF  in  1  start a forward FFT (level, sampled only in IDLE).
- startI  in  1  start an inverse FFT.
- filter  in  1  with startF, chain FFT → filter → IFFT.
- log2N  in  4  requested log2 of the transform size, sampled with start.
- sigNum  in  SIG_W  signal number, sampled with start.
- inFifoReady  in  1  in-FIFO holds a complete frame.
- loadExternalDone  in  1  datapath finished loading the frame into RAM.
- unloadDone  in  1  out-FIFO unloader finished writing the frame back.
- calculating  out  1  high from start acceptance until done.
- sigNumMC  out  SIG_W  latched signal number.
- inverse  out  1  current calculation pass is an IFFT.
- loadExternal  out  1  datapath loads RAM from the in-FIFO.
- loadInternal  out  1  butterfly engine active.
- stageCount  out  $clog2(MAX_LOG2N)  current stage.
- cycleCount  out  MAX_LOG2N-1  butterfly index within the stage.
- filtering  out  1  filter multiplier active.
- filtAddr  out  MAX_LOG2N  filter coefficient and sample index.
- unload  out  1  datapath drains RAM to the out-FIFO.
- done  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, WAIT_IN, LOAD, CALC, FILT, UNLOAD, DONE.
- **IDLE**
  - On startF or startI, latch sigNum, mode and filter flag.
  - Latch the effective size L = clamp(log2N, MIN_LOG2N, MAX_LOG2N).
  - Go to WAIT_IN.
  - If startF and startI are both high, startF wins and inverse = 0.
  - filter is ignored with startI.
- **WAIT_IN**: on inFifoReady → LOAD.
- **LOAD**: loadExternal = 1 until the cycle loadExternalDone is sampled high, then → CALC.
- **CALC**
  - loadInternal = 1.
  - cycleCount runs 0..2^(L-1)-1.
  - At wrap, cycleCount returns to 0 and stageCount increments.
  - After stage L-1, cycle 2^(L-1)-1:
    - if a filter pass is pending and inverse = 0 → FILT;
    - otherwise → UNLOAD.
  - Counters clear on exit.
- **FILT**
  - filtering = 1; filtAddr runs 0..2^L-1, then → CALC with inverse = 1 and the pending flag cleared.
  - There is no reload from the FIFO; the data stays in RAM.
- **UNLOAD**: unload = 1 until unloadDone is sampled high, then → DONE.
- **DONE**: done = 1 for one cycle; calculating, inverse and sigNumMC-valid clear; → IDLE.
- Start pulses outside IDLE are ignored. The size and mode of a run are fixed once accepted.
- Unused high bits of cycleCount and filtAddr are 0 for L < MAX_LOG2N.

## Timing
- Reset values: all outputs 0, sigNumMC 0, state IDLE.
- A start is sampled at edge k. At edge k+1, calculating = 1 and sigNumMC = sigNum.
- loadExternal rises on the edge after inFifoReady is sampled high in WAIT_IN.
  - If inFifoReady is already high at start, loadExternal rises 2 cycles after acceptance.
- loadExternalDone and loadInternal:
  - loadExternal stays high during the cycle in which loadExternalDone is high.
  - loadInternal rises on the next edge, with stageCount = 0 and cycleCount = 0.
- Calculation pass length: exactly L·2^(L-1) cycles with loadInternal high. There are no bubbles between stages.
- FILT lasts exactly 2^L cycles. The inverse pass begins on the next edge.
- After unloadDone is sampled, done pulses on the following cycle.
- Total latency, excluding external waits: L·2^(L-1), plus 2^L + L·2^(L-1) when chained, plus 3 control cycles.
- rst_n asserted mid-run: all outputs drop asynchronously and the run is discarded. After release, the block waits in IDLE for a new start.

## Test plan
- **Reset values**: assert rst_n = 0 mid-CALC → all outputs 0 immediately; after release, startF is accepted normally.
- **Forward FFT, L = 10**: startF, sigNum = 1, log2N = 10 → sigNumMC = 1 and calculating = 1 next cycle.
  - Loading the FIFO gives loadExternal until loadExternalDone.
  - loadInternal is high for 5120 cycles; stageCount/cycleCount track 0..9 / 0..511.
  - Then unload; done pulses once after unloadDone.
- **Inverse FFT, L = 4**: startI, log2N = 4 → inverse = 1 and loadInternal high for 32 cycles, stages 0..3, cycles 0..7.
- **Chained filter, L = 6**:
  - startF with filter = 1 → 192 CALC cycles with inverse = 0.
  - Then 64 FILT cycles, filtAddr 0..63.
  - Then 192 CALC cycles with inverse = 1, then UNLOAD.
- **Clamping and arbitration**:
  - log2N = 15 behaves as L = 10.
  - log2N = 1 behaves as L = 3 (12 cycles).
  - startF and startI together → forward mode.
- **Busy protection**: startI pulsed during CALC → ignored; counters, mode and sigNumMC are unchanged.

Source files
------------

// File: rtl/fft_seq_ctrl_if.sv
// Host/datapath handshake bundle for the FFT control sequencer.
// Latency: none, wires only.
// Backpressure: level handshakes (inFifoReady, loadExternalDone, unloadDone) carry all flow control.
interface fft_seq_ctrl_if #(
    parameter int MAX_LOG2N = 10,
    parameter int SIG_W     = 18
);
    localparam int SW = $clog2(MAX_LOG2N);

    logic                 startF;
    logic                 startI;
    logic                 filter;
    logic [3:0]           log2N;
    logic [SIG_W-1:0]     sigNum;
    logic                 inFifoReady;
    logic                 loadExternalDone;
    logic                 unloadDone;

    logic                 calculating;
    logic [SIG_W-1:0]     sigNumMC;
    logic                 inverse;
    logic                 loadExternal;
    logic                 loadInternal;
    logic [SW-1:0]        stageCount;
    logic [MAX_LOG2N-2:0] cycleCount;
    logic                 filtering;
    logic [MAX_LOG2N-1:0] filtAddr;
    logic                 unload;
    logic                 done;

    // Sequencer side
    modport slave (
        input  startF, startI, filter, log2N, sigNum,
               inFifoReady, loadExternalDone, unloadDone,
        output calculating, sigNumMC, inverse, loadExternal, loadInternal,
               stageCount, cycleCount, filtering, filtAddr, unload, done
    );

    // Host / datapath side
    modport master (
        output startF, startI, filter, log2N, sigNum,
               inFifoReady, loadExternalDone, unloadDone,
        input  calculating, sigNumMC, inverse, loadExternal, loadInternal,
               stageCount, cycleCount, filtering, filtAddr, unload, done
    );
endinterface

// File: rtl/fft_seq_ctrl.sv
// FFT accelerator phase sequencer: load, butterfly stages, optional filter + inverse pass, unload.
// Latency: L*2^(L-1) calc cycles (x2 plus 2^L filter cycles when chained) plus 3 control cycles.
// Backpressure: stalls in WAIT_IN/LOAD/UNLOAD until the datapath handshake is sampled high.
module fft_seq_ctrl #(
    parameter int MAX_LOG2N = 10,
    parameter int MIN_LOG2N = 3,
    parameter int SIG_W     = 18
) (
    input  logic           clk,
    input  logic           rst_n,
    fft_seq_ctrl_if.slave  bus
);
    localparam int NW  = MAX_LOG2N;
    localparam int CW  = MAX_LOG2N - 1;
    localparam int SW  = $clog2(MAX_LOG2N);
    localparam int LW  = $clog2(MAX_LOG2N + 1);
    localparam int SPW = MAX_LOG2N + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IN, S_LOAD, S_CALC, S_FILT, S_UNLOAD, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    l_q, l_d;
    logic             inv_q, inv_d;
    logic             pend_q, pend_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [NW-1:0]    faddr_q, faddr_d;

    logic [LW-1:0]    l_req;
    logic [SPW-1:0]   span;
    logic [NW-1:0]    half_m1;
    logic [NW-1:0]    full_m1;
    logic             cyc_wrap;
    logic             stage_last;
    logic             filt_last;

    // Clamp the requested size and derive the per-run counter end points
    always_comb begin
        l_req = LW'(bus.log2N);
        if (int'(bus.log2N) < MIN_LOG2N)      l_req = LW'(MIN_LOG2N);
        else if (int'(bus.log2N) > MAX_LOG2N) l_req = LW'(MAX_LOG2N);
        span       = SPW'(1) << l_q;
        half_m1    = span[NW:1] - NW'(1);
        full_m1    = span[NW-1:0] - NW'(1);
        cyc_wrap   = ({1'b0, cyc_q} == half_m1);
        stage_last = (LW'(stage_q) == l_q - LW'(1));
        filt_last  = (faddr_q == full_m1);
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        inv_d   = inv_q;
        pend_d  = pend_q;
        sig_d   = sig_q;
        stage_d = stage_q;
        cyc_d   = cyc_q;
        faddr_d = faddr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.startF || bus.startI) begin
                    sig_d   = bus.sigNum;
                    l_d     = l_req;
                    inv_d   = ~bus.startF;
                    pend_d  = bus.startF & bus.filter;
                    state_d = S_WAIT_IN;
                end
            end
            S_WAIT_IN: if (bus.inFifoReady) state_d = S_LOAD;
            S_LOAD: begin
                if (bus.loadExternalDone) begin
                    stage_d = '0;
                    cyc_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cyc_wrap) begin
                    cyc_d = '0;
                    if (stage_last) begin
                        stage_d = '0;
                        faddr_d = '0;
                        state_d = (pend_q && !inv_q) ? S_FILT : S_UNLOAD;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_FILT: begin
                if (filt_last) begin
                    faddr_d = '0;
                    inv_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = S_CALC;
                end else begin
                    faddr_d = faddr_q + NW'(1);
                end
            end
            S_UNLOAD: if (bus.unloadDone) state_d = S_DONE;
            S_DONE: begin
                inv_d   = 1'b0;
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and run-context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            inv_q   <= 1'b0;
            pend_q  <= 1'b0;
            sig_q   <= '0;
            stage_q <= '0;
            cyc_q   <= '0;
            faddr_q <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            inv_q   <= inv_d;
            pend_q  <= pend_d;
            sig_q   <= sig_d;
            stage_q <= stage_d;
            cyc_q   <= cyc_d;
            faddr_q <= faddr_d;
        end
    end

    assign bus.calculating  = (state_q != S_IDLE);
    assign bus.sigNumMC     = sig_q;
    assign bus.inverse      = inv_q;
    assign bus.loadExternal = (state_q == S_LOAD);
    assign bus.loadInternal = (state_q == S_CALC);
    assign bus.stageCount   = stage_q;
    assign bus.cycleCount   = cyc_q;
    assign bus.filtering    = (state_q == S_FILT);
    assign bus.filtAddr     = faddr_q;
    assign bus.unload       = (state_q == S_UNLOAD);
    assign bus.done         = (state_q == S_DONE);
endmodule
